// File: rtl/node_feeder_if.sv
// Node-feeder bus: upstream pair stream, node drive/return, downstream result stream.
// master = feeder side, slave = surrounding datapath (source, node, sink).
interface node_feeder_if #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 7,
   parameter int OUT_W  = 3
);
   logic              abort;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [DATA_W-1:0] in_coef;
   logic              node_reset_acc;
   logic              node_start;
   logic [CNT_W-1:0]  node_cnt_val;
   logic [DATA_W-1:0] node_data;
   logic [DATA_W-1:0] node_coef;
   logic [OUT_W-1:0]  node_out;
   logic              res_valid;
   logic              res_ready;
   logic [OUT_W-1:0]  res_data;
   logic              busy;

   modport master (
      input  abort, in_valid, in_data, in_coef, node_out, res_ready,
      output in_ready, node_reset_acc, node_start, node_cnt_val,
             node_data, node_coef, res_valid, res_data, busy
   );

   modport slave (
      output abort, in_valid, in_data, in_coef, node_out, res_ready,
      input  in_ready, node_reset_acc, node_start, node_cnt_val,
             node_data, node_coef, res_valid, res_data, busy
   );
endinterface

// File: rtl/node_feeder.sv
// Buffers one vector of data/coef pairs, clears and streams it into a node, captures node_out
// NODE_LAT cycles after the last sample and holds it until res_ready; in_ready only while loading.
module node_feeder #(
   parameter int DATA_W   = 16,
   parameter int NUM_IN   = 64,
   parameter int CNT_W    = 7,
   parameter int OUT_W    = 3,
   parameter int NODE_LAT = 2
) (
   input  logic          clk,
   input  logic          rst,
   node_feeder_if.master bus
);

   localparam int PTR_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
   localparam int WCNT_W = (NODE_LAT > 1) ? $clog2(NODE_LAT) : 1;
   localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(NUM_IN - 1);
   localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(NODE_LAT - 1);

   typedef enum logic [2:0] {
      S_LOAD,
      S_CLEAR,
      S_STREAM,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [WCNT_W-1:0]   wait_q, wait_d;
   logic                res_valid_q, res_valid_d;
   logic [OUT_W-1:0]    res_data_q, res_data_d;
   logic                wr_en;
   logic [2*DATA_W-1:0] vec_mem [NUM_IN];
   logic [2*DATA_W-1:0] rd_word;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      wait_d      = wait_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      wr_en       = 1'b0;

      case (state_q)
         S_LOAD: begin
            if (bus.in_valid) begin
               wr_en = 1'b1;
               if (wr_ptr_q == LAST_IDX) begin
                  wr_ptr_d = '0;
                  state_d  = S_CLEAR;
               end else begin
                  wr_ptr_d = wr_ptr_q + PTR_W'(1);
               end
            end
         end
         S_CLEAR: begin
            rd_ptr_d = '0;
            state_d  = S_STREAM;
         end
         S_STREAM: begin
            if (rd_ptr_q == LAST_IDX) begin
               rd_ptr_d = '0;
               wait_d   = WAIT_INIT;
               state_d  = S_WAIT;
            end else begin
               rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
         end
         S_WAIT: begin
            // node_out is sampled on the edge that ends the last wait cycle
            if (wait_q == '0) begin
               res_data_d  = bus.node_out;
               res_valid_d = 1'b1;
               state_d     = S_HOLD;
            end else begin
               wait_d = wait_q - WCNT_W'(1);
            end
         end
         S_HOLD: begin
            if (bus.res_ready) begin
               res_valid_d = 1'b0;
               state_d     = S_LOAD;
            end
         end
         default: state_d = S_LOAD;
      endcase

      // abort outranks every transition, including a pending result handshake
      if (bus.abort) begin
         state_d     = S_LOAD;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         wait_d      = '0;
         res_valid_d = 1'b0;
         res_data_d  = res_data_q;
         wr_en       = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_LOAD;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         wait_q      <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         wait_q      <= wait_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         vec_mem[wr_ptr_q] <= {bus.in_data, bus.in_coef};
      end
   end

   assign rd_word = vec_mem[rd_ptr_q];

   assign bus.in_ready       = (state_q == S_LOAD);
   assign bus.busy           = (state_q != S_LOAD);
   assign bus.node_reset_acc = (state_q == S_CLEAR);
   assign bus.node_start     = (state_q == S_STREAM);
   assign bus.node_cnt_val   = (state_q == S_STREAM) ? CNT_W'(rd_ptr_q) : '0;
   assign bus.node_data      = (state_q == S_STREAM) ? rd_word[2*DATA_W-1:DATA_W] : '0;
   assign bus.node_coef      = (state_q == S_STREAM) ? rd_word[DATA_W-1:0] : '0;
   assign bus.res_valid      = res_valid_q;
   assign bus.res_data       = res_data_q;

endmodule

// File: tb/tb_node_feeder.sv
// Bench for node_feeder: loads queue expected strobes/results, a negedge monitor pops and
// compares them, and scenario tasks check timing, back-pressure, abort and reset behaviour.
module tb_node_feeder;

   localparam int NUM_IN = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   node_feeder_if bus ();
   node_feeder dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic [6:0]  cnt;
      logic [15:0] d;
      logic [15:0] c;
   } exp_t;

   exp_t       sb_stream[$];
   logic [2:0] sb_res[$];
   int         checks = 0;
   int         errors = 0;
   logic       rv_prev = 1'b0;
   exp_t       mon_got, mon_exp;
   logic [2:0] mon_res;

   // Scoreboard monitor: every strobe and every rising res_valid must match the next expectation.
   always @(negedge clk) begin
      if (rst) begin
         rv_prev = 1'b0;
      end else begin
         if (bus.node_start) begin
            mon_got = {bus.node_cnt_val, bus.node_data, bus.node_coef};
            checks++;
            if (sb_stream.size() == 0) begin
               errors++;
               $display("FAIL stream_extra got cnt=%0d data=%0d required no strobe", bus.node_cnt_val, bus.node_data);
            end else begin
               mon_exp = sb_stream.pop_front();
               if (mon_got !== mon_exp) begin
                  errors++;
                  $display("FAIL stream got cnt=%0d data=%0d coef=%0d required cnt=%0d data=%0d coef=%0d",
                           mon_got.cnt, mon_got.d, mon_got.c, mon_exp.cnt, mon_exp.d, mon_exp.c);
               end
            end
         end
         if (bus.res_valid && !rv_prev) begin
            checks++;
            if (sb_res.size() == 0) begin
               errors++;
               $display("FAIL result_extra got res_data=%0d required no result", bus.res_data);
            end else begin
               mon_res = sb_res.pop_front();
               if (bus.res_data !== mon_res) begin
                  errors++;
                  $display("FAIL result got res_data=%0d required %0d", bus.res_data, mon_res);
               end
            end
         end
         rv_prev = bus.res_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Drives one vector (optionally with in_valid toggling); entered and left at a negedge.
   // On return, the last pair was accepted on the immediately preceding posedge.
   task automatic load_vec(input int seed, input bit toggle);
      int i = 0;
      int n = 0;
      while (i < NUM_IN && n < 400) begin
         if (toggle && (n % 2 == 1)) begin
            bus.in_valid = 1'b0;
         end else begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(i + seed * 256);
            bus.in_coef  = 16'(2 * i + seed);
            if (bus.in_ready) begin
               sb_stream.push_back({7'(i), 16'(i + seed * 256), 16'(2 * i + seed)});
               i++;
            end
         end
         n++;
         @(negedge clk);
      end
      if (i < NUM_IN) begin
         checks++;
         errors++;
         $display("FAIL load_timeout got %0d accepts required %0d", i, NUM_IN);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %0b required 0", bus.res_valid); end
      checks++; if (bus.res_data !== 3'd0) begin errors++; $display("FAIL rst_res_data got %0d required 0", bus.res_data); end
      checks++; if (bus.node_start !== 1'b0) begin errors++; $display("FAIL rst_node_start got %0b required 0", bus.node_start); end
      checks++; if (bus.node_reset_acc !== 1'b0) begin errors++; $display("FAIL rst_reset_acc got %0b required 0", bus.node_reset_acc); end
      checks++; if (bus.node_cnt_val !== 7'd0) begin errors++; $display("FAIL rst_cnt_val got %0d required 0", bus.node_cnt_val); end
      checks++; if (bus.node_data !== 16'd0 || bus.node_coef !== 16'd0) begin errors++; $display("FAIL rst_node_bus got %0d/%0d required 0/0", bus.node_data, bus.node_coef); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b required 0", bus.busy); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b required 1", bus.in_ready); end
   endtask

   task automatic test_basic();
      int resets = 0;
      int starts = 0;
      int first_rv = 0;
      bus.node_out = 3'd5;
      sb_res.push_back(3'd5);
      load_vec(0, 1'b0);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_drop got %0b required 0", bus.in_ready); end
      for (int c = 1; c <= 70; c++) begin
         if (bus.node_reset_acc) resets++;
         if (bus.node_start) starts++;
         if (bus.res_valid && first_rv == 0) first_rv = c;
         if (c == 66) bus.in_valid = 1'b0;
         @(negedge clk);
      end
      checks++; if (resets !== 1) begin errors++; $display("FAIL basic_reset_pulses got %0d required 1", resets); end
      checks++; if (starts !== 64) begin errors++; $display("FAIL basic_strobes got %0d required 64", starts); end
      checks++; if (first_rv - 1 !== 67) begin errors++; $display("FAIL basic_latency got %0d required 67", first_rv - 1); end
   endtask

   task automatic test_hold();
      for (int c = 0; c < 20; c++) begin
         checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL hold_res_valid cyc %0d got %0b required 1", c, bus.res_valid); end
         checks++; if (bus.res_data !== 3'd5) begin errors++; $display("FAIL hold_res_data cyc %0d got %0d required 5", c, bus.res_data); end
         checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cyc %0d got %0b required 0", c, bus.in_ready); end
         checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL hold_busy cyc %0d got %0b required 1", c, bus.busy); end
         @(negedge clk);
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid got %0b required 0", bus.res_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_in_ready got %0b required 1", bus.in_ready); end
      checks++; if (bus.res_data !== 3'd5) begin errors++; $display("FAIL hold_release_data got %0d required 5", bus.res_data); end
   endtask

   task automatic test_toggle();
      int starts = 0;
      bit seen17 = 1'b0;
      bus.node_out = 3'd3;
      sb_res.push_back(3'd3);
      load_vec(0, 1'b1);
      bus.in_valid = 1'b0;
      for (int c = 0; c < 200 && !bus.res_valid; c++) begin
         if (bus.node_start) starts++;
         if (bus.node_start && bus.node_cnt_val == 7'd17) begin
            seen17 = 1'b1;
            checks++; if (bus.node_data !== 16'd17) begin errors++; $display("FAIL toggle_idx17 got %0d required 17", bus.node_data); end
         end
         @(negedge clk);
      end
      checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL toggle_timeout got res_valid=%0b required 1", bus.res_valid); end
      checks++; if (starts !== 64) begin errors++; $display("FAIL toggle_strobes got %0d required 64", starts); end
      checks++; if (seen17 !== 1'b1) begin errors++; $display("FAIL toggle_seen17 got %0b required 1", seen17); end
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL toggle_handshake got %0b required 0", bus.res_valid); end
   endtask

   task automatic test_abort();
      int c = 0;
      bit saw = 1'b0;
      bus.node_out = 3'd6;
      sb_res.push_back(3'd6);
      load_vec(3, 1'b0);
      bus.in_valid = 1'b0;
      while (!(bus.node_start && bus.node_cnt_val == 7'd30) && c < 100) begin
         @(negedge clk);
         c++;
      end
      checks++; if (bus.node_cnt_val !== 7'd30) begin errors++; $display("FAIL abort_reach30 got %0d required 30", bus.node_cnt_val); end
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      sb_stream.delete();
      sb_res.delete();
      checks++; if (bus.node_start !== 1'b0) begin errors++; $display("FAIL abort_node_start got %0b required 0", bus.node_start); end
      checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL abort_state got busy=%0b in_ready=%0b required 0/1", bus.busy, bus.in_ready); end
      for (int k = 0; k < 80; k++) begin
         if (bus.res_valid) saw = 1'b1;
         @(negedge clk);
      end
      checks++; if (saw !== 1'b0) begin errors++; $display("FAIL abort_no_result got %0b required 0", saw); end
      bus.node_out = 3'd1;
      sb_res.push_back(3'd1);
      load_vec(4, 1'b0);
      bus.in_valid = 1'b0;
      checks++; if (bus.node_reset_acc !== 1'b1) begin errors++; $display("FAIL abort_reload_clear got %0b required 1", bus.node_reset_acc); end
      @(negedge clk);
      checks++; if (bus.node_start !== 1'b1 || bus.node_cnt_val !== 7'd0 || bus.node_data !== 16'd1024) begin
         errors++; $display("FAIL abort_reload_first got start=%0b cnt=%0d data=%0d required 1/0/1024", bus.node_start, bus.node_cnt_val, bus.node_data);
      end
      for (int k = 0; k < 200 && !bus.res_valid; k++) @(negedge clk);
      checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL abort_reload_timeout got %0b required 1", bus.res_valid); end
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
   endtask

   task automatic test_rst_wait();
      bit saw = 1'b0;
      bus.node_out = 3'd7;
      sb_res.push_back(3'd7);
      load_vec(5, 1'b0);
      bus.in_valid = 1'b0;
      for (int c = 1; c <= 65; c++) @(negedge clk);
      checks++; if (bus.busy !== 1'b1 || bus.node_start !== 1'b0 || bus.res_valid !== 1'b0) begin
         errors++; $display("FAIL rstw_in_wait got busy=%0b start=%0b rv=%0b required 1/0/0", bus.busy, bus.node_start, bus.res_valid);
      end
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstw_async_busy got %0b required 0", bus.busy); end
      checks++; if (bus.res_valid !== 1'b0 || bus.node_reset_acc !== 1'b0 || bus.node_start !== 1'b0) begin
         errors++; $display("FAIL rstw_async_outputs got rv=%0b acc=%0b start=%0b required 0/0/0", bus.res_valid, bus.node_reset_acc, bus.node_start);
      end
      sb_stream.delete();
      sb_res.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 80; k++) begin
         if (bus.res_valid) saw = 1'b1;
         @(negedge clk);
      end
      checks++; if (saw !== 1'b0) begin errors++; $display("FAIL rstw_no_result got %0b required 0", saw); end
   endtask

   task automatic test_back_to_back();
      bus.res_ready = 1'b1;
      bus.node_out  = 3'd4;
      sb_res.push_back(3'd4);
      load_vec(6, 1'b0);
      bus.in_valid = 1'b0;
      for (int k = 0; k < 200 && !bus.res_valid; k++) @(negedge clk);
      checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_timeout got %0b required 1", bus.res_valid); end
      bus.node_out = 3'd2;
      sb_res.push_back(3'd2);
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_turnaround got in_ready=%0b rv=%0b required 1/0", bus.in_ready, bus.res_valid);
      end
      load_vec(7, 1'b0);
      bus.in_valid = 1'b0;
      for (int k = 0; k < 200 && !bus.res_valid; k++) @(negedge clk);
      checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 3'd2) begin
         errors++; $display("FAIL b2b_second got rv=%0b data=%0d required 1/2", bus.res_valid, bus.res_data);
      end
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL b2b_handshake got %0b required 0", bus.res_valid); end
      bus.res_ready = 1'b0;
   endtask

   initial begin
      bus.abort     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_coef   = '0;
      bus.node_out  = '0;
      bus.res_ready = 1'b0;

      test_reset();
      test_basic();
      test_hold();
      test_toggle();
      test_abort();
      test_rst_wait();
      test_back_to_back();

      repeat (3) @(negedge clk);
      checks++; if (sb_stream.size() != 0) begin errors++; $display("FAIL sb_stream_left got %0d required 0", sb_stream.size()); end
      checks++; if (sb_res.size() != 0) begin errors++; $display("FAIL sb_res_left got %0d required 0", sb_res.size()); end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
